// File: rtl/dcmac_tx_4to2.sv
// Narrows 4-segment DCMAC TX beats into 2-segment pairs through one holding register.
// Phase A presents segments 0/1 and phase B presents segments 2/3; short beats end after phase A.
module dcmac_tx_4to2 (
  input  logic         clk,
  input  logic         resetn,
  input  logic [127:0] in0_tdata,
  input  logic [3:0]   in0_tid,
  input  logic [2:0]   in0_tuser,
  input  logic         in0_tlast,
  input  logic [127:0] in1_tdata,
  input  logic [3:0]   in1_tid,
  input  logic [2:0]   in1_tuser,
  input  logic         in1_tlast,
  input  logic [127:0] in2_tdata,
  input  logic [3:0]   in2_tid,
  input  logic [2:0]   in2_tuser,
  input  logic         in2_tlast,
  input  logic [127:0] in3_tdata,
  input  logic [3:0]   in3_tid,
  input  logic [2:0]   in3_tuser,
  input  logic         in3_tlast,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [127:0] out0_tdata,
  output logic [3:0]   out0_tid,
  output logic [2:0]   out0_tuser,
  output logic         out0_tlast,
  output logic         out0_tvalid,
  output logic [127:0] out1_tdata,
  output logic [3:0]   out1_tid,
  output logic [2:0]   out1_tuser,
  output logic         out1_tlast,
  output logic         out1_tvalid,
  input  logic         out_tready
);

  typedef enum logic {PH_A, PH_B} phase_t;

  phase_t              phase, phase_nxt;
  logic                h_valid, h_valid_nxt, h_short;
  logic [3:0][127:0]   h_data;
  logic [3:0][3:0]     h_id;
  logic [3:0][2:0]     h_user;
  logic [3:0]          h_last;

  logic in_short, in_a_empty, last_pair, in_fire, out_fire;

  assign in_short   = in0_tlast | in1_tlast | ~in2_tuser[2];
  // Pair A carries no enabled segment: start in phase B, or drop the beat if there is no B pair.
  assign in_a_empty = ~in0_tuser[2] & (in0_tlast | ~in1_tuser[2]);

  assign last_pair  = (phase == PH_B) | h_short;
  assign in_tready  = ~h_valid | (last_pair & out_tready);
  assign in_fire    = in_tvalid & in_tready;
  assign out_fire   = h_valid & out_tready;

  always_comb begin
    h_valid_nxt = h_valid;
    phase_nxt   = phase;
    if (in_fire) begin
      h_valid_nxt = ~(in_a_empty & in_short);
      phase_nxt   = (in_a_empty & ~in_short) ? PH_B : PH_A;
    end else if (out_fire) begin
      if (last_pair) begin
        h_valid_nxt = 1'b0;
        phase_nxt   = PH_A;
      end else begin
        phase_nxt   = PH_B;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_valid <= 1'b0;
      phase   <= PH_A;
    end else begin
      h_valid <= h_valid_nxt;
      phase   <= phase_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_data  <= '0;
      h_id    <= '0;
      h_user  <= '0;
      h_last  <= '0;
      h_short <= 1'b0;
    end else if (in_fire) begin
      h_data  <= {in3_tdata, in2_tdata, in1_tdata, in0_tdata};
      h_id    <= {in3_tid, in2_tid, in1_tid, in0_tid};
      h_user  <= {in3_tuser, in2_tuser, in1_tuser, in0_tuser};
      h_last  <= {in3_tlast, in2_tlast, in1_tlast, in0_tlast};
      h_short <= in_short;
    end
  end

  // Outputs read only registered state; out1 is blanked after an eop on segment 0.
  always_comb begin
    out0_tdata = '0;
    out0_tid   = '0;
    out0_tuser = '0;
    out0_tlast = 1'b0;
    out1_tdata = '0;
    out1_tid   = '0;
    out1_tuser = '0;
    out1_tlast = 1'b0;
    if (h_valid) begin
      if (phase == PH_A) begin
        out0_tdata = h_data[0];
        out0_tid   = h_id[0];
        out0_tuser = h_user[0];
        out0_tlast = h_last[0];
        if (!h_last[0]) begin
          out1_tdata = h_data[1];
          out1_tid   = h_id[1];
          out1_tuser = h_user[1];
          out1_tlast = h_last[1];
        end
      end else begin
        out0_tdata = h_data[2];
        out0_tid   = h_id[2];
        out0_tuser = h_user[2];
        out0_tlast = h_last[2];
        out1_tdata = h_data[3];
        out1_tid   = h_id[3];
        out1_tuser = h_user[3];
        out1_tlast = h_last[3];
      end
    end
  end

  assign out0_tvalid = h_valid;
  assign out1_tvalid = h_valid;

endmodule
